sine_phase_sequencer: RTL and testbench

- Phase-accumulator sequencer that drives the 6-bit select (S0..S5) of the sine generator's 64:1 output multiplexer.
- Advances an ACC_W-bit phase accumulator by a frequency tuning word every clock and presents the top 6 bits as the mux select.
- Counts completed waveform periods and supports continuous or fixed-length bursts.
- Applies tuning-word changes only at period boundaries, so frequency changes are phase-continuous.

---
 rtl/sine_phase_sequencer.sv | 142 ++++++++++++++
 tb/tb_sine_phase_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/sine_phase_sequencer.sv
// sine_phase_sequencer
// Phase-accumulator sequencer for the sine generator's 64:1 output mux.
// The top six accumulator bits form the mux select. The sequencer counts
// completed waveform periods and can run continuously or for a fixed burst.
// A tuning word written while running is held as pending and becomes active
// only at a period boundary, so frequency changes are phase-continuous.
//
// state  | meaning
// IDLE   | accumulator parked at 0; tuning word loads the active register directly
// RUN    | accumulator advancing; sel is live
// FINISH | one-cycle terminal state; done and wrap pulse, then back to IDLE
module sine_phase_sequencer #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [ACC_W-1:0] ftw,
  input  logic             ftw_valid,
  output logic             ftw_ready,
  output logic [5:0]       sel,
  output logic             sel_valid,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] periods
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] ftw_act;
  logic [ACC_W-1:0] ftw_pend;
  logic             pend_full;
  logic             stop_lat;
  logic [CNT_W-1:0] blen;

  logic [ACC_W:0]   sum;
  logic             carry;
  logic [CNT_W-1:0] periods_inc;
  logic             last_period;
  logic             ftw_fire;

  // Accumulator add with carry out; the carry marks a period boundary.
  assign sum         = {1'b0, acc} + {1'b0, ftw_act};
  assign carry       = sum[ACC_W];
  assign periods_inc = periods + CNT_W'(1);
  // A stop arriving on the overflow cycle itself still ends at this boundary.
  assign last_period = stop || stop_lat || ((blen != '0) && (periods_inc == blen));

  // In IDLE a word goes straight to the active register, so it is always accepted;
  // elsewhere it needs an empty pending slot.
  assign ftw_ready = (state == IDLE) || !pend_full;
  assign ftw_fire  = ftw_valid && ftw_ready;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      ftw_act   <= '0;
      ftw_pend  <= '0;
      pend_full <= 1'b0;
      stop_lat  <= 1'b0;
      blen      <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      periods   <= '0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          acc <= '0;
          if (ftw_fire) ftw_act <= ftw;
          // A zero increment would never advance the phase, so start is refused.
          if (start && (ftw_act != '0)) begin
            state     <= RUN;
            periods   <= '0;
            blen      <= burst_len;
            stop_lat  <= 1'b0;
            sel       <= '0;
            sel_valid <= 1'b1;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (ftw_fire) begin
            ftw_pend  <= ftw;
            pend_full <= 1'b1;
          end
          if (stop) stop_lat <= 1'b1;
          if (carry) begin
            wrap    <= 1'b1;
            periods <= periods_inc;
            if (pend_full) begin
              ftw_act   <= ftw_pend;
              pend_full <= 1'b0;
            end
            if (last_period) begin
              state     <= FINISH;
              done      <= 1'b1;
              acc       <= '0;
              sel       <= '0;
              sel_valid <= 1'b0;
              busy      <= 1'b0;
            end else begin
              acc <= sum[ACC_W-1:0];
              sel <= sum[ACC_W-1 -: 6];
            end
          end else begin
            acc <= sum[ACC_W-1:0];
            sel <= sum[ACC_W-1 -: 6];
          end
        end
        FINISH: begin
          state    <= IDLE;
          acc      <= '0;
          stop_lat <= 1'b0;
          // A word still pending at the end of the burst becomes active here.
          if (pend_full) begin
            ftw_act   <= ftw_pend;
            pend_full <= 1'b0;
          end else if (ftw_fire) begin
            ftw_act <= ftw;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench for sine_phase_sequencer with hand-computed expectations.
module tb_sine_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [7:0]  burst_len = '0;
  logic [15:0] ftw = '0;
  logic        ftw_valid = 1'b0;
  logic        ftw_ready;
  logic [5:0]  sel;
  logic        sel_valid;
  logic        wrap;
  logic        busy;
  logic        done;
  logic [7:0]  periods;

  int n_chk  = 0;
  int n_pass = 0;

  sine_phase_sequencer #(.ACC_W(16), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .ftw       (ftw),
    .ftw_valid (ftw_valid),
    .ftw_ready (ftw_ready),
    .sel       (sel),
    .sel_valid (sel_valid),
    .wrap      (wrap),
    .busy      (busy),
    .done      (done),
    .periods   (periods)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ftw(input logic [15:0] w);
    ftw       = w;
    ftw_valid = 1'b1;
    tick();
    ftw_valid = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] bl);
    burst_len = bl;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    int es;
    // reset
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_sel", sel, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_done", done, 0);
    chk("rst_periods", periods, 0);
    chk("rst_ftw_ready", ftw_ready, 1);

    // start with ftw=0 is ignored
    do_start(8'd0);
    chk("zero_busy", busy, 0);
    chk("zero_sel_valid", sel_valid, 0);
    tick();
    chk("zero_busy2", busy, 0);

    // burst of 2 periods at ftw=0x0400
    load_ftw(16'h0400);
    do_start(8'd2);
    for (int c = 0; c <= 129; c++) begin
      es = (c < 128) ? (c % 64) : 0;
      chk($sformatf("a_sel_%0d", c), sel, es);
      chk($sformatf("a_wrap_%0d", c), wrap, (c == 64 || c == 128) ? 1 : 0);
      chk($sformatf("a_done_%0d", c), done, (c == 128) ? 1 : 0);
      chk($sformatf("a_busy_%0d", c), busy, (c < 128) ? 1 : 0);
      chk($sformatf("a_svalid_%0d", c), sel_valid, (c < 128) ? 1 : 0);
      if (c == 64) chk("a_periods_64", periods, 1);
      if (c == 129) chk("a_periods_end", periods, 2);
      tick();
    end

    // continuous; ftw change at cycle 10, stalled second word, then stop
    do_start(8'd0);
    for (int c = 0; c <= 129; c++) begin
      if (c < 64) es = c;
      else if (c < 128) es = (2 * (c - 64)) % 64;
      else es = 0;
      chk($sformatf("b_sel_%0d", c), sel, es);
      chk($sformatf("b_wrap_%0d", c), wrap, (c == 64 || c == 96 || c == 128) ? 1 : 0);
      chk($sformatf("b_done_%0d", c), done, (c == 128) ? 1 : 0);
      if (c == 10) begin
        chk("b_ready_10", ftw_ready, 1);
        ftw = 16'h0800;
        ftw_valid = 1'b1;
      end
      if (c >= 11 && c <= 20) begin
        chk($sformatf("b_stall_%0d", c), ftw_ready, 0);
        ftw = 16'h0C00;
        ftw_valid = 1'b1;
      end
      if (c == 21) ftw_valid = 1'b0;
      if (c == 63) chk("b_ready_63", ftw_ready, 0);
      if (c == 64) chk("b_ready_64", ftw_ready, 1);
      stop = (c == 100);
      if (c == 129) begin
        chk("b_periods_end", periods, 3);
        chk("b_busy_end", busy, 0);
      end
      tick();
    end
    stop = 1'b0;

    // stop pulse mid-period at ftw=0x0400
    load_ftw(16'h0400);
    do_start(8'd0);
    for (int c = 0; c <= 65; c++) begin
      chk($sformatf("c_done_%0d", c), done, (c == 64) ? 1 : 0);
      chk($sformatf("c_busy_%0d", c), busy, (c < 64) ? 1 : 0);
      if (c == 64) chk("c_periods", periods, 1);
      stop = (c == 20);
      tick();
    end
    stop = 1'b0;

    // stop exactly on the overflow cycle
    do_start(8'd0);
    for (int c = 0; c <= 65; c++) begin
      chk($sformatf("d_done_%0d", c), done, (c == 64) ? 1 : 0);
      chk($sformatf("d_wrap_%0d", c), wrap, (c == 64) ? 1 : 0);
      if (c == 64) chk("d_periods", periods, 1);
      stop = (c == 63);
      tick();
    end
    stop = 1'b0;

    // ftw=0x8000, burst of 3
    load_ftw(16'h8000);
    do_start(8'd3);
    for (int c = 0; c <= 7; c++) begin
      es = (c < 6) ? ((c % 2) * 32) : 0;
      chk($sformatf("e_sel_%0d", c), sel, es);
      chk($sformatf("e_wrap_%0d", c), wrap, (c == 2 || c == 4 || c == 6) ? 1 : 0);
      chk($sformatf("e_done_%0d", c), done, (c == 6) ? 1 : 0);
      chk($sformatf("e_busy_%0d", c), busy, (c < 6) ? 1 : 0);
      if (c == 6) chk("e_periods", periods, 3);
      tick();
    end

    // reset in the middle of RUN
    load_ftw(16'h0400);
    do_start(8'd0);
    for (int c = 0; c < 40; c++) tick();
    chk("f_busy_pre", busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("f_sel", sel, 0);
    chk("f_sel_valid", sel_valid, 0);
    chk("f_busy", busy, 0);
    chk("f_periods", periods, 0);
    chk("f_done", done, 0);
    chk("f_ftw_ready", ftw_ready, 1);
    do_start(8'd0);
    chk("f_restart_busy", busy, 0);
    chk("f_restart_svalid", sel_valid, 0);
    tick();
    chk("f_restart_busy2", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
